// File: rtl/seq_expect_checker.sv
// seq_expect_checker: multi-channel synthesizable stand-in for the blocking
// sequence expect `req1 ##[MIN_DLY:MAX_DLY] req2`.
// Each channel is armed by start_i. It needs req1 on the start edge and req2
// somewhere inside the delay window. It reports one-cycle pass/fail/start_drop
// pulses and saturating pass/fail counters.
//
// Optional build macro: SEQ_CHK_STRICT_EARLY_EN
//   defined   -> req2 seen before MIN_DLY fails the check at once, and every
//                fail raises a simulation-only $error naming the channel.
//   undefined -> early req2 is ignored.
//
// Per-channel states:
//   state  | meaning
//   S_IDLE | no check in flight; start_i arms a new check
//   S_WAIT | req1 accepted; watching req2 until the window closes
module seq_expect_checker #(
  parameter int NUM_CH  = 2,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 2,
  parameter int CNT_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       start_i,
  input  logic [NUM_CH-1:0]       req1_i,
  input  logic [NUM_CH-1:0]       req2_i,
  input  logic                    cnt_clr_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       pass_o,
  output logic [NUM_CH-1:0]       fail_o,
  output logic [NUM_CH-1:0]       start_drop_o,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt_o,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt_o
);

  localparam int            DW        = $clog2(MAX_DLY + 1);
  localparam logic [DW-1:0] MIN_V     = DW'(MIN_DLY);
  localparam logic [DW-1:0] MAX_V     = DW'(MAX_DLY);
  localparam bit            MIN_ZERO  = (MIN_DLY == 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [DW-1:0]    dly_q, dly_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             min_ok;

    // An unsigned ">= 0" compare is always true, so MIN_DLY=0 is special-cased.
    if (MIN_ZERO) begin : g_min0
      assign min_ok = 1'b1;
    end else begin : g_minn
      assign min_ok = (dly_q >= MIN_V);
    end

    // Register state, delay count, result pulses and counters.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        dly_q   <= '0;
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
        drop_q  <= 1'b0;
        pcnt_q  <= '0;
        fcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        dly_q   <= dly_d;
        pass_q  <= pass_d;
        fail_q  <= fail_d;
        drop_q  <= drop_d;
        pcnt_q  <= pcnt_d;
        fcnt_q  <= fcnt_d;
      end
    end

    // Next-state decision and result/counter updates for one channel.
    always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      drop_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i[g]) begin
            if (!req1_i[g]) begin
              fail_d = 1'b1;
            end else if (MIN_ZERO && req2_i[g]) begin
              pass_d = 1'b1;
`ifdef SEQ_CHK_STRICT_EARLY_EN
            end else if (req2_i[g]) begin
              fail_d = 1'b1;
`endif
            end else begin
              state_d = S_WAIT;
              dly_d   = DW'(1);
            end
          end
        end
        S_WAIT: begin
          // A start during a check in flight is only reported, never queued.
          drop_d = start_i[g];
          if (min_ok && req2_i[g]) begin
            pass_d  = 1'b1;
            state_d = S_IDLE;
            dly_d   = '0;
`ifdef SEQ_CHK_STRICT_EARLY_EN
          end else if (req2_i[g]) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
            dly_d   = '0;
`endif
          end else if (dly_q == MAX_V) begin
            fail_d  = 1'b1;
            state_d = S_IDLE;
            dly_d   = '0;
          end else begin
            dly_d = dly_q + DW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          dly_d   = '0;
        end
      endcase

      pcnt_d = pcnt_q;
      fcnt_d = fcnt_q;
      if (cnt_clr_i) begin
        pcnt_d = '0;
        fcnt_d = '0;
      end else begin
        if (pass_d && (pcnt_q != CNT_MAX)) pcnt_d = pcnt_q + CNT_W'(1);
        if (fail_d && (fcnt_q != CNT_MAX)) fcnt_d = fcnt_q + CNT_W'(1);
      end
    end

`ifdef SEQ_CHK_STRICT_EARLY_EN
    // Simulation-only notice on every fail decision.
    always @(posedge clk_i) begin
      if (!rst_i && fail_d) $error("seq_expect_checker: channel %0d check failed", g);
    end
`endif

    assign busy_o[g]                    = (state_q == S_WAIT);
    assign pass_o[g]                    = pass_q;
    assign fail_o[g]                    = fail_q;
    assign start_drop_o[g]              = drop_q;
    assign pass_cnt_o[g*CNT_W +: CNT_W] = pcnt_q;
    assign fail_cnt_o[g*CNT_W +: CNT_W] = fcnt_q;
  end

endmodule

// File: tb/tb_seq_expect_checker.sv
// Bench for seq_expect_checker: two instances (default config, and a
// 1-channel MIN=1/MAX=3/CNT_W=4 config) checked every cycle against an
// offset-based reference model, plus directed scenarios.
module tb_seq_expect_checker;

`ifdef SEQ_CHK_STRICT_EARLY_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cnt_clr;
  logic [1:0]  a_start, a_req1, a_req2, a_busy, a_pass, a_fail, a_drop;
  logic [15:0] a_pcnt, a_fcnt;
  logic [0:0]  b_start, b_req1, b_req2, b_busy, b_pass, b_fail, b_drop;
  logic [3:0]  b_pcnt, b_fcnt;

  seq_expect_checker #(.NUM_CH(2), .MIN_DLY(2), .MAX_DLY(2), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .req1_i(a_req1), .req2_i(a_req2),
    .cnt_clr_i(cnt_clr), .busy_o(a_busy), .pass_o(a_pass), .fail_o(a_fail),
    .start_drop_o(a_drop), .pass_cnt_o(a_pcnt), .fail_cnt_o(a_fcnt));

  seq_expect_checker #(.NUM_CH(1), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .req1_i(b_req1), .req2_i(b_req2),
    .cnt_clr_i(cnt_clr), .busy_o(b_busy), .pass_o(b_pass), .fail_o(b_fail),
    .start_drop_o(b_drop), .pass_cnt_o(b_pcnt), .fail_cnt_o(b_fcnt));

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a check in flight is remembered by its start cycle;
  // the window is judged on the offset k = now - start.
  int cyc = 0;
  int m_act [2][2];
  int m_t0  [2][2];
  int e_busy[2][2];
  int e_pass[2][2];
  int e_fail[2][2];
  int e_drop[2][2];
  int e_pc  [2][2];
  int e_fc  [2][2];

  function automatic int p_min(int d);  return (d == 0) ? 2 : 1;   endfunction
  function automatic int p_max(int d);  return (d == 0) ? 2 : 3;   endfunction
  function automatic int p_cmax(int d); return (d == 0) ? 255 : 15; endfunction
  function automatic int p_nch(int d);  return (d == 0) ? 2 : 1;   endfunction

  task automatic model_step();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < p_nch(d); c++) begin
        bit s, r1, r2, np, nf, nd;
        int k;
        s  = (d == 0) ? a_start[c] : b_start[0];
        r1 = (d == 0) ? a_req1[c]  : b_req1[0];
        r2 = (d == 0) ? a_req2[c]  : b_req2[0];
        np = 0; nf = 0; nd = 0;
        if (rst) begin
          m_act[d][c] = 0;
          e_pc[d][c]  = 0;
          e_fc[d][c]  = 0;
        end else begin
          if (m_act[d][c] != 0) begin
            k  = cyc - m_t0[d][c];
            nd = s;
            if (r2 && k >= p_min(d))      begin np = 1; m_act[d][c] = 0; end
            else if (STRICT && r2)        begin nf = 1; m_act[d][c] = 0; end
            else if (k >= p_max(d))       begin nf = 1; m_act[d][c] = 0; end
          end else if (s) begin
            if (!r1)                       nf = 1;
            else if (r2 && p_min(d) == 0)  np = 1;
            else if (r2 && STRICT)         nf = 1;
            else begin m_act[d][c] = 1; m_t0[d][c] = cyc; end
          end
          if (cnt_clr) begin
            e_pc[d][c] = 0;
            e_fc[d][c] = 0;
          end else begin
            if (np && e_pc[d][c] < p_cmax(d)) e_pc[d][c]++;
            if (nf && e_fc[d][c] < p_cmax(d)) e_fc[d][c]++;
          end
        end
        e_pass[d][c] = np;
        e_fail[d][c] = nf;
        e_drop[d][c] = nd;
        e_busy[d][c] = m_act[d][c];
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < p_nch(d); c++) begin
        string p;
        p = $sformatf("d%0d.ch%0d", d, c);
        if (d == 0) begin
          chk_eq({p, ".busy"}, a_busy[c], e_busy[d][c]);
          chk_eq({p, ".pass"}, a_pass[c], e_pass[d][c]);
          chk_eq({p, ".fail"}, a_fail[c], e_fail[d][c]);
          chk_eq({p, ".drop"}, a_drop[c], e_drop[d][c]);
          chk_eq({p, ".pcnt"}, a_pcnt[c*8 +: 8], e_pc[d][c]);
          chk_eq({p, ".fcnt"}, a_fcnt[c*8 +: 8], e_fc[d][c]);
        end else begin
          chk_eq({p, ".busy"}, b_busy[0], e_busy[d][c]);
          chk_eq({p, ".pass"}, b_pass[0], e_pass[d][c]);
          chk_eq({p, ".fail"}, b_fail[0], e_fail[d][c]);
          chk_eq({p, ".drop"}, b_drop[0], e_drop[d][c]);
          chk_eq({p, ".pcnt"}, b_pcnt, e_pc[d][c]);
          chk_eq({p, ".fcnt"}, b_fcnt, e_fc[d][c]);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    a_start = '0; a_req1 = '0; a_req2 = '0;
    b_start = '0; b_req1 = '0; b_req2 = '0;
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    tick();
    tick();
    chk_eq("rst.a_busy", a_busy, 0);
    chk_eq("rst.a_pcnt", a_pcnt, 0);
    rst = 1'b0;
    tick();

    // ch0 passes at offset 2 while ch1 fails on req1=0 in parallel.
    a_start = 2'b11; a_req1 = 2'b01;
    tick();
    chk_eq("t1.busy0_T+1", a_busy[0], 1);
    chk_eq("t1.fail1_T+1", a_fail[1], 1);
    chk_eq("t1.busy1_T+1", a_busy[1], 0);
    a_start = '0; a_req1 = '0;
    tick();
    chk_eq("t1.busy0_T+2", a_busy[0], 1);
    a_req2 = 2'b01;
    tick();
    chk_eq("t1.pass0_T+3", a_pass[0], 1);
    chk_eq("t1.busy0_T+3", a_busy[0], 0);
    chk_eq("t1.pcnt0", a_pcnt[7:0], 1);
    chk_eq("t1.fcnt1", a_fcnt[15:8], 1);
    a_req2 = '0;
    tick();
    chk_eq("t1.pass0_T+4", a_pass[0], 0);

    // Window expires without req2; a start in WAIT is dropped.
    a_start = 2'b01; a_req1 = 2'b01;
    tick();
    a_req1 = '0;
    tick();
    chk_eq("t3.drop0_T+2", a_drop[0], 1);
    a_start = '0;
    tick();
    chk_eq("t3.fail0_T+3", a_fail[0], 1);
    chk_eq("t3.pcnt0", a_pcnt[7:0], 1);
    chk_eq("t3.fcnt0", a_fcnt[7:0], 1);
    tick();

    // Reset mid-WAIT aborts silently; a later check works normally.
    a_start = 2'b01; a_req1 = 2'b01;
    tick();
    a_start = '0; a_req1 = '0; a_req2 = 2'b01; rst = 1'b1;
    tick();
    chk_eq("t5.busy_rst", a_busy, 0);
    rst = 1'b0;
    tick();
    chk_eq("t5.pass_after_rst", a_pass, 0);
    a_req2 = '0; a_start = 2'b01; a_req1 = 2'b01;
    tick();
    a_start = '0; a_req1 = '0;
    tick();
    a_req2 = 2'b01;
    tick();
    chk_eq("t5.pass_new", a_pass[0], 1);
    a_req2 = '0;
    tick();

    // MIN=1 on dut_b with req1=req2=1 on the start edge and req2 held.
    b_start = 1'b1; b_req1 = 1'b1; b_req2 = 1'b1;
    tick();
    chk_eq("t6.fail_T+1", b_fail, STRICT ? 1 : 0);
    b_start = 1'b0; b_req1 = 1'b0;
    tick();
    chk_eq("t6.pass_T+2", b_pass, STRICT ? 0 : 1);
    b_req2 = 1'b0;
    tick();

    // 20 back-to-back passes saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      b_start = 1'b1; b_req1 = 1'b1; b_req2 = 1'b0;
      tick();
      b_start = 1'b0; b_req1 = 1'b0; b_req2 = 1'b1;
      tick();
    end
    b_req2 = 1'b0;
    tick();
    chk_eq("t4.sat", b_pcnt, 15);
    b_start = 1'b1; b_req1 = 1'b1;
    tick();
    b_start = 1'b0; b_req1 = 1'b0; b_req2 = 1'b1; cnt_clr = 1'b1;
    tick();
    chk_eq("t4.clr_pass", b_pass, 1);
    chk_eq("t4.clr_cnt", b_pcnt, 0);
    idle_inputs();
    tick();

    // Randomized traffic on both instances.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        a_start[c] = ($urandom_range(0, 2) == 0);
        a_req1[c]  = ($urandom_range(0, 3) != 0);
        a_req2[c]  = ($urandom_range(0, 2) == 0);
      end
      b_start[0] = ($urandom_range(0, 2) == 0);
      b_req1[0]  = ($urandom_range(0, 3) != 0);
      b_req2[0]  = ($urandom_range(0, 2) == 0);
      cnt_clr    = ($urandom_range(0, 99) == 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
